// File: rtl/tmpl_rom_arbiter.sv
// tmpl_rom_arbiter
// Shares one single-port template ROM among NUM_REQ matching engines.
// Each engine asks for a burst of req_len consecutive bytes starting at
// req_base. Requests are granted round-robin, and the granted burst streams
// back as tagged response beats with a last marker.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   req_valid    per-requester burst request, held until req_ready
//   req_ready    one-hot, single-cycle accept pulse
//   req_base     packed start addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len      packed burst lengths (beats), requester i at [i*LEN_WIDTH +: LEN_WIDTH]
//   rom_addr     ROM address, holds its last value outside ISSUE
//   rom_rd_data  ROM read data, valid ROM_LATENCY cycles after rom_addr
//   rsp_valid    response beat valid (no backpressure)
//   rsp_data     response byte
//   rsp_id       owning requester index
//   rsp_last     final beat of the burst
//   busy         high while a burst is issuing or draining
module tmpl_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LEN_WIDTH   = 11,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned ID_WIDTH    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0]           rom_rd_data,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ID_WIDTH-1:0]             rsp_id,
  output logic                            rsp_last,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LATENCY - 1);

  state_t                 state;
  logic [ID_WIDTH-1:0]    ptr;
  logic [ID_WIDTH-1:0]    id_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_cnt;
  logic [1:0]             drain_cnt;

  logic [ROM_LATENCY-1:0] pipe_v;
  logic [ROM_LATENCY-1:0] pipe_last;
  logic [ID_WIDTH-1:0]    pipe_id [ROM_LATENCY];

  logic                   pick_any;
  logic [ID_WIDTH-1:0]    pick_idx;
  logic [ADDR_WIDTH-1:0]  pick_base;
  logic [LEN_WIDTH-1:0]   pick_len;
  logic [NUM_REQ-1:0]     ready_next;
  logic                   do_grant;
  logic                   issue_v;
  logic                   issue_last;

  // Round-robin pick: first pass covers [ptr, NUM_REQ), second pass wraps
  // to [0, ptr). The first hit wins.
  always_comb begin
    pick_any   = 1'b0;
    pick_idx   = '0;
    pick_base  = '0;
    pick_len   = '0;
    ready_next = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_any && req_valid[i] && (i >= 32'(ptr))) begin
        pick_any      = 1'b1;
        pick_idx      = ID_WIDTH'(i);
        pick_base     = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_len      = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        ready_next    = '0;
        ready_next[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_any && req_valid[i]) begin
        pick_any      = 1'b1;
        pick_idx      = ID_WIDTH'(i);
        pick_base     = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_len      = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        ready_next    = '0;
        ready_next[i] = 1'b1;
      end
    end
  end

  // A grant is registered, so req_ready is high in the cycle after the
  // decision. Deciding in the final DRAIN cycle lets the accept pulse land
  // in the first cycle after DRAIN; an IDLE cycle already showing req_ready
  // never decides again.
  assign do_grant = pick_any &&
                    (((state == IDLE) && (req_ready == '0)) ||
                     ((state == DRAIN) && (drain_cnt == DRAIN_LAST)));

  assign issue_v    = (state == ISSUE);
  assign issue_last = issue_v && (beat_cnt == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      base_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      req_ready <= '0;
      rom_addr  <= '0;
      pipe_v    <= '0;
      pipe_last <= '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      req_ready <= '0;

      // Valid/id/last ride alongside the ROM read so they line up with rom_rd_data.
      pipe_v[0]    <= issue_v;
      pipe_last[0] <= issue_last;
      pipe_id[0]   <= issue_v ? id_q : '0;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_id[i]   <= pipe_id[i-1];
      end

      case (state)
        IDLE: begin
          if (req_ready != '0) begin
            // Zero-length bursts are accepted but issue nothing.
            if (len_q != '0) begin
              state    <= ISSUE;
              rom_addr <= base_q;
              beat_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          if (beat_cnt == len_q - LEN_WIDTH'(1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= IDLE;
          else drain_cnt <= drain_cnt + 2'd1;
        end
        default: state <= IDLE;
      endcase

      if (do_grant) begin
        req_ready <= ready_next;
        base_q    <= pick_base;
        len_q     <= pick_len;
        id_q      <= pick_idx;
        ptr       <= (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_WIDTH'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = pipe_v[ROM_LATENCY-1];
  assign rsp_last  = pipe_last[ROM_LATENCY-1];
  assign rsp_id    = pipe_id[ROM_LATENCY-1];
  assign rsp_data  = rsp_valid ? rom_rd_data : '0;

endmodule

// File: doc/tmpl_rom_arbiter.md
Name: tmpl_rom_arbiter

Overview:
- Shares one single-port fruit-template ROM (11-bit address, 8-bit data, unregistered output, 1-cycle read latency) among NUM_REQ feature-matching engines.
- Each engine requests a burst read of req_len consecutive bytes from a base address.
- Grants are round-robin. The granted burst streams back as a tagged response stream with a last marker.
- Sits between the per-fruit matching engines and the template ROM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 11, ROM address width
- DATA_WIDTH, 8, ROM data width
- LEN_WIDTH, 11, burst length field width (beats)
- ROM_LATENCY, 1, cycles from rom_addr to valid rom_rd_data (1..3)
- ID_WIDTH, 2, rsp_id width (must be at least clog2(NUM_REQ))

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester burst request, held until accepted
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse
- req_base  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_REQ*LEN_WIDTH  packed burst lengths in beats
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_rd_data  in  DATA_WIDTH  ROM read data
- rsp_valid  out  1  response beat valid
- rsp_data  out  DATA_WIDTH  response byte
- rsp_id  out  ID_WIDTH  index of the owning requester
- rsp_last  out  1  final beat of the burst
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer 0 (requester 0 highest priority); response pipeline flushed.
- States:
  - IDLE: if any req_valid, grant the first requester at or after the pointer (wrapping), then go to ISSUE. Else stay.
  - ISSUE: drive one address per cycle, len beats total. After the last address go to DRAIN.
  - DRAIN: wait ROM_LATENCY cycles, then go to IDLE.
- Grant (cycle T, in IDLE):
  - req_ready[g]=1 for exactly that cycle.
  - Latch base, len and id.
  - Pointer becomes (g+1) mod NUM_REQ.
  - Requesters must drop or change req_valid only after seeing req_ready.
- Issue:
  - rom_addr = base at T+1, base+1 at T+2, and so on.
  - Address arithmetic is modulo 2^ADDR_WIDTH: 0x7FF is followed by 0x000.
- Response:
  - Valid, id and last travel through a ROM_LATENCY-deep shift register aligned with rom_rd_data.
  - Beat k appears at T+1+ROM_LATENCY+k with rsp_data = rom_rd_data.
  - rsp_last=1 only on beat len-1.
  - There is no response backpressure; consumers must accept every beat.
- Timing:
  - Accept-to-first-beat latency is 1+ROM_LATENCY cycles.
  - The next grant occurs at the earliest in the cycle after DRAIN completes.
  - Bursts never overlap on rsp.
- rom_addr holds its last value outside ISSUE.
- req_len = 0: the request is accepted (req_ready pulse) and the FSM returns to IDLE the next cycle. No addresses are issued, no rsp beats are produced, and the pointer still advances.
- Simultaneous requests: exactly one grant per IDLE visit. A requester re-asserting immediately after its grant waits behind the other pending requesters.
- Requests arriving during ISSUE/DRAIN are held off (req_ready=0) until IDLE.
- Reset mid-burst (rst high in any cycle):
  - Next cycle is IDLE with rsp_valid=0 and req_ready=0.
  - No partial last beat is emitted.
  - Pointer returns to 0.
- busy=1 in ISSUE and DRAIN, and in the cycle after a grant.

Test Plan:
- Single burst: req_valid=0001, base0=0x010, len0=4, ROM_LATENCY=1, ROM holding data=addr[7:0]. Required: req_ready=0001 for 1 cycle; rom_addr 0x010..0x013; rsp_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting 2 cycles after accept; rsp_id=0; rsp_last on 0x13 only.
- Round-robin: all four requesters held with len=2. Required: grants in order 0,1,2,3,0; rsp_id sequence 0,0,1,1,2,2,3,3; no overlap between bursts; each burst separated by the DRAIN cycle.
- Address wrap: base=0x7FE, len=4. Required: rom_addr 0x7FE,0x7FF,0x000,0x001; 4 rsp beats; last on the 4th.
- Zero length: requester 2 with len=0 and requester 3 with len=1 both pending, pointer at 2. Required: req_ready[2] pulse with no rsp beats; next grant is requester 3 with 1 beat, rsp_last=1, rsp_id=3.
- Reset mid-burst: len=8, rst asserted for one cycle after beat 3. Required: rsp_valid=0 the following cycle; busy=0; no rsp_last seen; the next request from requester 1 is granted with pointer reset (requester 0 wins if both are pending).
- ROM_LATENCY=3 build: len=2. Required: first beat 4 cycles after accept; DRAIN lasts 3 cycles before the next req_ready.
